mips_seg_display: RTL and testbench

Seven-segment display controller that consumes a 32-bit observation value from the MIPS CPU and shows 16 bits of it as four hex digits on a common-anode 4-digit display. It sits downstream of the CPU/memory top level. It holds a snapshot register loaded by a strobe and scans the digits with a prescaled refresh counter. Between digits it inserts blanking guard intervals to suppress ghosting. Digit contents are latched once per digit period, so a display update never tears mid-digit.

---
 rtl/mips_seg_display.sv | 138 +++++++++++++
 tb/tb_mips_seg_display.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mips_seg_display.sv
// Four-digit common-anode seven-segment scanner for the MIPS observation port.
// A strobed snapshot holds the 32-bit value. A two-state scan (BLANK guard,
// then DRIVE) walks digits 0..3. The digit pattern is captured at DRIVE entry,
// so a digit never changes while it is lit.
module mips_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Data_In,
  input  logic        Data_Valid,
  input  logic        Freeze,
  input  logic        Half_Sel,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        Frame_Tick
);

  localparam int MAX_CNT = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    idx_q,   idx_d;
  logic [31:0]   snap_q,  snap_d;
  logic [3:0]    an_q,    an_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;
  logic          tick_q,  tick_d;

  logic [15:0]   half;
  logic [3:0]    nibble;

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // Next-state logic for the snapshot, the scan FSM and the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    tick_d  = 1'b0;
    snap_d  = (Data_Valid && !Freeze) ? Data_In : snap_q;

    half   = Half_Sel ? snap_q[31:16] : snap_q[15:0];
    nibble = half[{idx_q, 2'b00} +: 4];

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          an_d    = ~(4'b0001 << idx_q);
          seg_d   = seg_decode(nibble);
          dp_d    = !((idx_q == 2'd3) && Half_Sel);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          an_d    = 4'b1111;
          seg_d   = 7'b1111111;
          dp_d    = 1'b1;
          tick_d  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 32'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign Frame_Tick = tick_q;

endmodule

// File: tb/tb_mips_seg_display.sv
// Testbench for mips_seg_display. The reference tracks elapsed edges since
// reset release. It derives the lit digit, the blanking windows and the frame
// pulse from the digit period. It captures the digit content from a model
// snapshot at each digit start.
module tb_mips_seg_display;

  localparam int RD = 8;
  localparam int G  = 2;
  localparam int P  = RD + G;
  localparam int F  = 4 * P;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Data_In;
  logic        Data_Valid;
  logic        Freeze;
  logic        Half_Sel;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        Frame_Tick;

  int checks = 0;
  int fails  = 0;
  int n      = 0;

  logic [31:0] m_snap   = 32'd0;
  int          lat_dig  = 0;
  logic [6:0]  lat_seg  = 7'h7F;
  logic        lat_dp   = 1'b1;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  mips_seg_display #(.REFRESH_DIV(RD), .GUARD(G)) dut (
    .CLK(CLK),
    .RST(RST),
    .Data_In(Data_In),
    .Data_Valid(Data_Valid),
    .Freeze(Freeze),
    .Half_Sel(Half_Sel),
    .AN(AN),
    .SEG(SEG),
    .DP(DP),
    .Frame_Tick(Frame_Tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;
    if (RST == 1'b0 || (n % P) < G) begin
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << lat_dig);
      e_seg = lat_seg;
      e_dp  = lat_dp;
    end
    e_tick = (RST == 1'b1) && (n > 0) && ((n % F) == 0);
    check("AN", 32'(AN), 32'(e_an));
    check("SEG", 32'(SEG), 32'(e_seg));
    check("DP", 32'(DP), 32'(e_dp));
    check("Frame_Tick", 32'(Frame_Tick), 32'(e_tick));
  endtask

  task automatic applyStimulus();
    int d;
    logic [15:0] half;
    @(posedge CLK);
    if (RST == 1'b0) begin
      n      = 0;
      m_snap = 32'd0;
    end else begin
      n++;
      if ((n % P) == G) begin
        d       = (n / P) % 4;
        half    = Half_Sel ? m_snap[31:16] : m_snap[15:0];
        lat_dig = d;
        lat_seg = seg_tab[int'((half >> (4 * d)) & 16'hF)];
        lat_dp  = (d == 3 && Half_Sel) ? 1'b0 : 1'b1;
      end
      if (Data_Valid && !Freeze) m_snap = Data_In;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus();
  endtask

  task automatic strobe(input logic [31:0] val);
    Data_In    = val;
    Data_Valid = 1'b1;
    applyStimulus();
    Data_Valid = 1'b0;
  endtask

  initial begin
    RST        = 1'b0;
    Data_In    = 32'd0;
    Data_Valid = 1'b0;
    Freeze     = 1'b0;
    Half_Sel   = 1'b0;

    // Reset held with the clock running.
    #2;
    run(3);

    // Release; the first digit appears after GUARD edges showing 0.
    RST = 1'b1;
    run(12);

    // Lower half of 0x12345678 for two frames.
    strobe(32'h12345678);
    run(2 * F);

    // Upper half of the same value; DP lit on digit 3.
    Half_Sel = 1'b1;
    run(2 * F);
    Half_Sel = 1'b0;

    // Frozen strobe is ignored, unfrozen strobe loads.
    Freeze = 1'b1;
    strobe(32'hDEADBEEF);
    run(2 * F + 10);
    Freeze = 1'b0;
    strobe(32'hDEADBEEF);
    run(F + 5);

    // Update three cycles into digit 2's drive window.
    for (int i = 0; i < F && (n % F) != (2 * P + G + 3); i++) applyStimulus();
    strobe($urandom);
    run(F + 5);

    // Asynchronous reset while digit 1 is lit.
    for (int i = 0; i < F && (n % F) != (P + G + 3); i++) applyStimulus();
    #2;
    RST = 1'b0;
    #1;
    check_outputs();
    run(2);
    RST = 1'b1;
    run(F + 10);

    // Randomized strobes, freezes and half selects.
    for (int i = 0; i < 400; i++) begin
      Data_In    = $urandom;
      Data_Valid = ($urandom_range(0, 3) == 0);
      Freeze     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) Half_Sel = ~Half_Sel;
      applyStimulus();
    end
    Data_Valid = 1'b0;
    Freeze     = 1'b0;
    run(F);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
